cordic_ci_ctrl: RTL
===================

// Module: cordic_ci_ctrl
// PURPOSE
//  Multi-cycle custom-instruction controller for the iterative CORDIC cosine core.
//  Accepts an angle from the processor and launches the core.
//  Converts the core's unsigned fixed-point cosine (range 0.5..1.0) to IEEE-754 single and returns it.
//  Guards against a hung core (timeout) and out-of-range results.
// PARAMETERS
//  FRACS    21               fractional bits of core_result
//  INTS     1                integer bits of core_result
//  WIDTH    INTS+FRACS       core_result width (unsigned, no sign bit)
//  TIMEOUT  64               max cycles waited for core_done before abort (>=2)
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      asynchronous active-low reset
//  clk_en       in   1      clock enable; FSM, counter and all registers hold when low
//  start        in   1      one-cycle request strobe from processor
//  dataa        in   32     angle operand, passed through unmodified
//  done         out  1      one-cycle completion strobe
//  result       out  32     IEEE-754 single cosine result
//  core_start   out  1      one-cycle launch pulse to CORDIC core
//  core_angle   out  32     registered angle to core
//  core_done    in   1      core completion strobe
//  core_result  in   WIDTH  core unsigned fixed-point output, valid with core_done
//  busy         out  1      high from accepted start until done
//  err_timeout  out  1      sticky: a request was aborted by timeout
//  err_range    out  1      sticky: a core_result was below 0.5
// BEHAVIOUR
//  - Reset (async, reset_n=0): FSM->IDLE; all outputs 0; counter 0; stickies cleared; any late core_done ignored.
//  - Register updates occur only on clk edges with clk_en=1.
//  - States: IDLE -> LAUNCH -> WAIT -> CONVERT -> RESP -> IDLE.
//  - IDLE: on start=1, latch dataa into core_angle, set busy=1, go to LAUNCH.
//  - start while busy: ignored. No queueing.
//  - LAUNCH: drive core_start=1 for exactly one enabled cycle, clear the counter, go to WAIT.
//  - WAIT: core_done is sampled only in this state. core_done coinciding with core_start is ignored.
//  - WAIT, core_done=1: capture core_result, go to CONVERT.
//  - WAIT, no core_done, counter==TIMEOUT-1: set err_timeout, force the NaN path, go to CONVERT.
//  - WAIT, otherwise: counter+1.
//  - CONVERT: register the converted float into result. Rules, applied in order:
//    * timeout        -> 32'h7FC00000 (quiet NaN)
//    * msb set (1.0)  -> 32'h3F800000
//    * bit WIDTH-2 set -> {1'b0, 8'd126, mant}
//      mant = {core_result[WIDTH-3:0], zeros}, left-aligned to 23 bits; truncate LSBs if WIDTH-2>23.
//    * top two bits 0 (value <0.5) -> clamp to 32'h3F000000 and set err_range.
//  - RESP: done=1 for one cycle; busy drops in the same cycle; go to IDLE.
//  - result is held until the next CONVERT.
//  - Latency: start@T -> core_start@T+1. core_done@D -> done@D+2.
//  - Best case: done at T+4 when core_done arrives at T+2.
//  - clk_en=0 during a core_done pulse: the pulse is missed and the timeout path applies.
// TESTING
//  1. start, dataa=32'h12345678; core_done 5 cycles after core_start, core_result=22'h200000
//     -> core_angle=32'h12345678, result=32'h3F800000, done 2 cycles after core_done.
//  2. core_result=22'h180000 (0.75) -> result=32'h3F400000, no errors.
//     core_result=22'h100000 (0.5)  -> result=32'h3F000000, no errors.
//  3. core_result=22'h0C0000 -> result=32'h3F000000, err_range=1 (sticky across next request).
//  4. core_done never asserted -> after TIMEOUT WAIT cycles: result=32'h7FC00000, err_timeout=1, done pulses;
//     a later core_done in IDLE is ignored.
//  5. second start while busy -> ignored. core_start pulses once, done pulses once.
//  6. reset_n low mid-WAIT -> outputs 0 immediately. After release, a new request completes normally.
//     Also: clk_en low for 3 cycles in WAIT -> latency extends by 3 cycles, result correct.

Source files
------------

// File: rtl/cordic_ci_ctrl.sv
// cordic_ci_ctrl
//   Multi-cycle custom-instruction controller for an iterative CORDIC cosine
//   core. Latches the processor's angle, launches the core, waits for its
//   completion, converts the unsigned fixed-point cosine (0.5..1.0) to an
//   IEEE-754 single and returns it with a one-cycle done strobe. A hung core
//   is aborted after TIMEOUT wait cycles (quiet NaN). Results below 0.5 are
//   clamped to 0.5 and flagged.
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   clk_en         clock enable; all state holds when low
//   start, dataa   request strobe and angle operand from the processor
//   done, result   completion strobe and float result to the processor
//   core_start     one-cycle launch pulse to the core
//   core_angle     registered angle to the core
//   core_done      core completion strobe
//   core_result    core unsigned fixed-point cosine, valid with core_done
//   busy           high from accepted start until the response
//   err_timeout    sticky: a request was aborted by timeout
//   err_range      sticky: a core result was below 0.5
module cordic_ci_ctrl #(
  parameter int unsigned FRACS   = 21,
  parameter int unsigned INTS    = 1,
  parameter int unsigned WIDTH   = INTS + FRACS,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [31:0]      dataa,
  output logic             done,
  output logic [31:0]      result,
  output logic             core_start,
  output logic [31:0]      core_angle,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_range
);

  localparam int unsigned FRAC_W = WIDTH - 2;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);
  localparam int unsigned ALN_W  = FRAC_W + MANT_W;

  localparam logic [31:0] F_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] F_ONE  = 32'h3F80_0000;
  localparam logic [31:0] F_HALF = 32'h3F00_0000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_CONVERT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t             stateQ, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [WIDTH-1:0]   capVal, capValNext;
  logic               timedOut, timedOutNext;
  logic               lastWait;

  logic               doneNext, coreStartNext, busyNext;
  logic               errTimeoutNext, errRangeNext;
  logic [31:0]        resultNext, coreAngleNext;

  // Fixed-point to float: values in [0.5,1) have exponent 2^-1 and the bits
  // below the 0.5 bit become the mantissa, left-aligned (padded or truncated).
  function automatic logic [31:0] toFloat(input logic isTimeout,
                                          input logic [WIDTH-1:0] fix);
    logic [ALN_W-1:0]  aligned;
    logic [MANT_W-1:0] mant;
    aligned = {fix[FRAC_W-1:0], {MANT_W{1'b0}}};
    mant    = MANT_W'(aligned >> FRAC_W);
    if (isTimeout)            toFloat = F_QNAN;
    else if (fix[WIDTH-1])    toFloat = F_ONE;
    else if (fix[WIDTH-2])    toFloat = {1'b0, 8'd126, mant};
    else                      toFloat = F_HALF;
  endfunction

  assign lastWait = (cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    stateQ <= S_IDLE;
    else if (clk_en) stateQ <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      S_IDLE:    if (start) stateNext = S_LAUNCH;
      S_LAUNCH:  stateNext = S_WAIT;
      S_WAIT:    if (core_done || lastWait) stateNext = S_CONVERT;
      S_CONVERT: stateNext = S_RESP;
      S_RESP:    stateNext = S_IDLE;
      default:   stateNext = S_IDLE;
    endcase
  end

  // Output / datapath next values; pulses default low, everything else holds
  always_comb begin
    doneNext       = 1'b0;
    coreStartNext  = 1'b0;
    busyNext       = busy;
    resultNext     = result;
    coreAngleNext  = core_angle;
    errTimeoutNext = err_timeout;
    errRangeNext   = err_range;
    cntNext        = cnt;
    capValNext     = capVal;
    timedOutNext   = timedOut;
    case (stateQ)
      S_IDLE: begin
        if (start) begin
          coreAngleNext = dataa;
          busyNext      = 1'b1;
          coreStartNext = 1'b1;
          timedOutNext  = 1'b0;
        end
      end
      S_LAUNCH: cntNext = '0;
      S_WAIT: begin
        // A completion on the last wait cycle wins over the timeout.
        if (core_done) begin
          capValNext = core_result;
        end else if (lastWait) begin
          timedOutNext   = 1'b1;
          errTimeoutNext = 1'b1;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      S_CONVERT: begin
        resultNext = toFloat(timedOut, capVal);
        if (!timedOut && (capVal[WIDTH-1 -: 2] == 2'b00)) errRangeNext = 1'b1;
        busyNext = 1'b0;
        doneNext = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done        <= 1'b0;
      core_start  <= 1'b0;
      busy        <= 1'b0;
      result      <= '0;
      core_angle  <= '0;
      err_timeout <= 1'b0;
      err_range   <= 1'b0;
      cnt         <= '0;
      capVal      <= '0;
      timedOut    <= 1'b0;
    end else if (clk_en) begin
      done        <= doneNext;
      core_start  <= coreStartNext;
      busy        <= busyNext;
      result      <= resultNext;
      core_angle  <= coreAngleNext;
      err_timeout <= errTimeoutNext;
      err_range   <= errRangeNext;
      cnt         <= cntNext;
      capVal      <= capValNext;
      timedOut    <= timedOutNext;
    end
  end

endmodule
